// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one-cycle key strobe.
// Optional auto-repeat of the strobe while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int CLK_IN         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_rows,
  output logic [3:0] o_cols,
  output logic [3:0] o_key,
  output logic       o_key_pe,
  output logic       o_held
);

  localparam int TICK_DIV = CLK_IN / SCAN_HZ;
  localparam int DW       = $clog2(TICK_DIV);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [DW-1:0] div_q;
  logic          tick;
  logic [1:0]    col_q, col_d, row_q, row_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [3:0]    key_q, key_d;
  logic          pe_q, pe_d, held_q, held_d;
  logic          single_low;
  logic [1:0]    low_row;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0]   rep_q, rep_d, rep_inc;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  assign tick = (div_q == DW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
      div_q   <= '0;
    end else begin
      sync1_q <= i_rows;
      rs_q    <= sync1_q;
      div_q   <= tick ? '0 : div_q + DW'(1);
    end
  end

  // Exactly one row low is a candidate key; zero or several lows are treated as no key.
  always_comb begin
    single_low = 1'b1;
    low_row    = 2'd0;
    case (rs_q)
      4'b1110: low_row = 2'd0;
      4'b1101: low_row = 2'd1;
      4'b1011: low_row = 2'd2;
      4'b0111: low_row = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pe_d    = 1'b0;
    held_d  = held_q;
    cnt_inc = cnt_q + 8'd1;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (single_low) begin
            row_d   = low_row;
            cnt_d   = 8'd1;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (single_low && (low_row == row_q)) begin
            if (cnt_inc == 8'(DEBOUNCE_TICKS)) begin
              key_d   = key_code(row_q, col_q);
              pe_d    = 1'b1;
              held_d  = 1'b1;
              cnt_d   = 8'd0;
              state_d = ST_PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = 8'd0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (rs_q == 4'hF) begin
            if (cnt_inc == 8'(DEBOUNCE_TICKS)) begin
              held_d  = 1'b0;
              cnt_d   = 8'd0;
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 8'd0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + 16'd1;
    if ((state_q == ST_PRESSED) && (state_d == ST_PRESSED)) begin
      if (tick && (rs_q != 4'hF)) begin
        // After the first repeat the counter parks at REPEAT_DELAY so later repeats are REPEAT_RATE apart.
        if (rep_inc == 16'(REPEAT_DELAY + REPEAT_RATE)) begin
          pe_d  = 1'b1;
          rep_d = 16'(REPEAT_DELAY);
        end else begin
          pe_d  = (rep_inc == 16'(REPEAT_DELAY));
          rep_d = rep_inc;
        end
      end
    end else begin
      rep_d = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= 8'd0;
      key_q   <= 4'h0;
      pe_q    <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      pe_q    <= pe_d;
      held_q  <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign o_cols   = ~(4'b0001 << col_q);
  assign o_key    = key_q;
  assign o_key_pe = pe_q;
  assign o_held   = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner driving a modelled 4x4 key matrix.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows, cols, key;
  logic       key_pe, held;
  logic [15:0] keys;
  logic [3:0] rows_low;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic prev_pe = 1'b0;
  logic [3:0] exp_q[$];
  int pe_times[$];

  keypad_scanner #(
    .CLK_IN(100), .SCAN_HZ(10), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rows(rows),
    .o_cols(cols), .o_key(key), .o_key_pe(key_pe), .o_held(held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows_low = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows_low[r] = 1'b1;
  end
  assign rows = ~rows_low;

  task automatic chk_eq(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_pe && prev_pe) chk_eq("pe_double", 1, 0);
      if (key_pe) begin
        pe_times.push_back(cyc);
        if (exp_q.size() == 0) chk_eq("spurious_pe", 1, 0);
        else chk_eq("key_code", key, exp_q.pop_front());
      end
      prev_pe = key_pe;
    end else begin
      prev_pe = 1'b0;
    end
  end

  task automatic wait_cols(input logic [3:0] want, input int max_cyc);
    int n = 0;
    while (cols !== want && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk_eq("wait_cols", cols, want);
  endtask

  task automatic wait_held(input logic want, input int max_cyc, output int n);
    n = 0;
    while (held !== want && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk_eq("wait_held", held, want);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] step_cols [5];
    int t;
    step_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_cols", cols, 4'b1110);
    chk_eq("rst_key", key, 0);
    chk_eq("rst_pe", key_pe, 0);
    chk_eq("rst_held", held, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_eq("col_step", cols, step_cols[k]);
      repeat (10) @(negedge clk);
    end

    // Press '#': row 3 / col 2
    wait_cols(4'b1110, 40);
    exp_q.push_back(4'hF);
    keys[14] = 1'b1;
    wait_cols(4'b1011, 40);
    t = 0;
    while (!key_pe && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk_eq("accept_latency", t, 30);
    chk_eq("held_rise", held, 1);
    for (int i = 0; i < 10; i++) begin
      chk_eq("cols_frozen", cols, 4'b1011);
      repeat (10) @(negedge clk);
    end
    keys[14] = 1'b0;
    wait_held(1'b0, 60, t);
    chk_eq("held_fall_win", int'(t >= 23 && t <= 32), 1);
    chk_eq("resume_col3", cols, 4'b0111);
    chk_eq("key_hold_F", key, 4'hF);

    // One-tick glitch on row 1 / col 1
    wait_cols(4'b1101, 50);
    keys[5] = 1'b1;
    repeat (10) @(negedge clk);
    keys[5] = 1'b0;
    repeat (60) @(negedge clk);
    chk_eq("glitch_held", held, 0);
    chk_eq("glitch_key", key, 4'hF);
    wait_cols(4'b1110, 40);

    // Ghost: rows 0 and 2 on col 0
    keys[0] = 1'b1;
    keys[8] = 1'b1;
    repeat (10) @(negedge clk);
    chk_eq("ghost_advance", cols, 4'b1101);
    repeat (70) @(negedge clk);
    chk_eq("ghost_held", held, 0);
    chk_eq("ghost_key", key, 4'hF);
    keys = '0;

    // Reset during debounce of key 5
    wait_cols(4'b1110, 50);
    wait_cols(4'b1101, 20);
    keys[5] = 1'b1;
    repeat (15) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_eq("midrst_cols", cols, 4'b1110);
    chk_eq("midrst_key", key, 0);
    chk_eq("midrst_pe", key_pe, 0);
    chk_eq("midrst_held", held, 0);
    keys[5] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk_eq("postrst_held", held, 0);
    chk_eq("postrst_key", key, 0);
    exp_q.push_back(4'h5);
    keys[5] = 1'b1;
    wait_held(1'b1, 120, t);
    chk_eq("key5", key, 4'h5);
    keys[5] = 1'b0;
    wait_held(1'b0, 60, t);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Hold key 0 (row 3 / col 1) for 10 ticks after acceptance
    wait_cols(4'b1110, 50);
    pe_times.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(4'h0);
    keys[13] = 1'b1;
    t = 0;
    while (!key_pe && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk_eq("rep_accept", key_pe, 1);
    repeat (100) @(negedge clk);
    keys[13] = 1'b0;
    wait_held(1'b0, 60, t);
    chk_eq("rep_count", pe_times.size(), 4);
    if (pe_times.size() == 4) begin
      chk_eq("rep_first", pe_times[1] - pe_times[0], 50);
      chk_eq("rep_second", pe_times[2] - pe_times[0], 70);
      chk_eq("rep_third", pe_times[3] - pe_times[0], 90);
    end
`endif

    repeat (20) @(negedge clk);
    chk_eq("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Upstream input stage for the digital lock. Scans a 4x4 matrix keypad and debounces presses.
- Delivers one key code plus a single-cycle strobe per accepted press.
- Integration: `o_key[3:0]` feeds the lock's digit input; `o_key_pe` feeds the getter's confirm input directly, with no external posedge detector needed.
- Hex layout:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D, with `*` = 4'hE and `#` = 4'hF.

## Interface
Parameters:
- `CLK_IN`, 50_000_000, input clock frequency in Hz.
- `SCAN_HZ`, 1000, scan tick rate; `TICK_DIV = CLK_IN/SCAN_HZ`, must be an integer ≥ 2.
- `DEBOUNCE_TICKS`, 4, consecutive matching ticks needed to accept a press or a release; range 2..255.
- `REPEAT_DELAY`, 500, ticks from acceptance to the first auto-repeat; used only with the macro.
- `REPEAT_RATE`, 100, ticks between subsequent repeats; used only with the macro.

Ports:
- `i_clk`, input, 1 bit: system clock.
- `i_reset_n`, input, 1 bit: asynchronous, active-low reset.
- `i_rows`, input, 4 bits: keypad rows, active-low (pulled up externally), asynchronous to `i_clk`.
- `o_cols`, output, 4 bits: column drive, active-low; exactly one bit low at any time.
- `o_key`, output, 4 bits: code of the last accepted key; holds until the next acceptance.
- `o_key_pe`, output, 1 bit: one-cycle strobe when `o_key` is (re)issued.
- `o_held`, output, 1 bit: high while the accepted key is considered pressed.

## Operation
- **Synchronisation:** `i_rows` passes through a 2-flop synchroniser; all decisions use the synchronised value `rs`.
- **Tick divider:** counter runs 0..TICK_DIV-1; `tick` is high in the cycle where the counter equals TICK_DIV-1.
- **Column drive:** column index `c` (0..3) drives `o_cols = ~(4'b1 << c)`.
  - Samples are taken only on `tick`, so the driven column settles for a full tick period.
- **FSM states and transitions:**
  - **SCAN**, on `tick`:
    - Exactly one `rs` bit low (row `r`): latch (r, c), set `cnt` = 1, go to DEBOUNCE; `c` holds.
    - `rs` all high, or two or more bits low (ghost/multi-press): `c` advances, wrapping 3 -> 0.
  - **DEBOUNCE**, on `tick`:
    - Same single row low: `cnt++`.
    - When `cnt` reaches DEBOUNCE_TICKS: load `o_key` from the table for (r, c), pulse `o_key_pe`, set `o_held` = 1, clear `cnt`, go to PRESSED.
    - Any other pattern: go to SCAN, advance `c`, emit no strobe.
  - **PRESSED**, on `tick`; column stays frozen:
    - `rs` all high: `cnt++`.
    - Any low bit: `cnt` = 0.
    - When `cnt` reaches DEBOUNCE_TICKS: `o_held` = 0, go to SCAN, advance `c`.
    - A second key pressed in the same column is ignored.
- **Key code:** computed from (row, col) via the layout table; 4-bit result, no arithmetic overflow is possible.
- **Reset**, asynchronous and possible in any state including mid-DEBOUNCE:
  - State = SCAN, `c` = 0, `o_cols` = 4'b1110.
  - `o_key` = 4'h0, `o_key_pe` = 0, `o_held` = 0.
  - All counters = 0; synchroniser flops = 4'hF.
  - After reset release, no strobe is emitted until a full debounce completes.

## Timing
- Column step: one column per TICK_DIV cycles while in SCAN; a full sweep takes 4·TICK_DIV cycles.
- Synchroniser latency: 2 cycles before a row change is visible on `rs`.
- Accept latency:
  - Detection tick T0, then confirmations at T1..T(N-1), with N = DEBOUNCE_TICKS.
  - `o_key_pe` and the `o_key` update occur in the cycle after tick T(N-1). `o_key` is valid in that same cycle.
- `o_held` rises together with `o_key_pe`. It falls in the cycle after the N-th consecutive all-high tick.
- `o_key_pe` is never high for two consecutive cycles.

## Configuration
- Macro: `KEYPAD_AUTOREPEAT_EN`.
- **Defined:**
  - In PRESSED, a repeat counter counts ticks on which `rs` still shows a low bit.
  - Re-pulse `o_key_pe` (same `o_key`) at REPEAT_DELAY ticks after acceptance, then every REPEAT_RATE ticks.
  - The counter clears on leaving PRESSED.
- **Undefined:** exactly one strobe per press; the repeat counter and the REPEAT_* parameters are unused and not synthesised.

## Test plan
All scenarios use `CLK_IN` = 100, `SCAN_HZ` = 10 (TICK_DIV = 10) and `DEBOUNCE_TICKS` = 3.
- **Reset, no keys:** all outputs at reset values; `o_cols` steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, 10 cycles per step.
- **Press `#`:** row 3 low while col 2 driven, held 10 ticks, then released → exactly one `o_key_pe` with `o_key` = 4'hF. `o_cols` stays 1011 while `o_held` = 1. `o_held` falls 3 ticks after release, then scanning resumes at col 3.
- **Short glitch:** row 1 low for 1 tick only on col 1 → no strobe, `o_key` unchanged, scan resumes.
- **Ghost press:** rows 0 and 2 low together on col 0 → no strobe, column keeps advancing.
- **Reset mid-press:** pulse `i_reset_n` low during DEBOUNCE of key 5 → outputs return to reset values immediately; no strobe until the key is released and re-pressed for 3 ticks.
- **Auto-repeat, macro defined:** `REPEAT_DELAY` = 5, `REPEAT_RATE` = 2; hold key 0 for 10 ticks after acceptance → 4 strobes, all with `o_key` = 4'h0, at acceptance, +5, +7 and +9 ticks.
